// File: rtl/slurm32_cpu_registers.sv
// Operand register file: two registered read ports with write-to-read bypass,
// one write port, and a combinational debug read port. r0 reads as zero.
module slurm32_cpu_registers #(
  parameter int unsigned REG_COUNT = 32,
  parameter int unsigned DATA_BITS = 32
) (
  input  logic                 CLK,
  input  logic                 RSTb,
  input  logic                 stall,
  input  logic [7:0]           regA_sel,
  input  logic [7:0]           regB_sel,
  input  logic [7:0]           regIn_sel,
  input  logic [DATA_BITS-1:0] regIn_data,
  input  logic                 regIn_wr,
  output logic [DATA_BITS-1:0] regA_out,
  output logic [DATA_BITS-1:0] regB_out,
  input  logic [7:0]           dbg_sel,
  output logic [DATA_BITS-1:0] dbg_data
);

  localparam int unsigned IdxW     = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam logic [8:0]  SelLimit = 9'(REG_COUNT);

  logic [DATA_BITS-1:0] regs_q [REG_COUNT];
  logic [DATA_BITS-1:0] rd_a, rd_b;
  logic                 wr_en;

  // All eight select bits take part, so aliases such as 8'h21 are rejected.
  function automatic logic sel_valid(input logic [7:0] sel);
    return (sel != 8'd0) && ({1'b0, sel} < SelLimit);
  endfunction

  assign wr_en = regIn_wr && sel_valid(regIn_sel);

  always_comb begin
    rd_a = '0;
    if (sel_valid(regA_sel)) begin
      if (regIn_wr && (regIn_sel == regA_sel)) rd_a = regIn_data;
      else                                     rd_a = regs_q[regA_sel[IdxW-1:0]];
    end
  end

  always_comb begin
    rd_b = '0;
    if (sel_valid(regB_sel)) begin
      if (regIn_wr && (regIn_sel == regB_sel)) rd_b = regIn_data;
      else                                     rd_b = regs_q[regB_sel[IdxW-1:0]];
    end
  end

  // Debug port sees array contents only; an in-flight write is not visible.
  always_comb begin
    dbg_data = '0;
    if (sel_valid(dbg_sel)) dbg_data = regs_q[dbg_sel[IdxW-1:0]];
  end

  // Writes proceed regardless of stall.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      for (int i = 0; i < int'(REG_COUNT); i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[regIn_sel[IdxW-1:0]] <= regIn_data;
    end
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      regA_out <= '0;
      regB_out <= '0;
    end else if (!stall) begin
      regA_out <= rd_a;
      regB_out <= rd_b;
    end
  end

endmodule

// File: tb/tb_slurm32_cpu_registers.sv
// Directed bench for slurm32_cpu_registers: reset, writes, r0/out-of-range,
// bypass, stall hold, async reset and shared selects.
module tb_slurm32_cpu_registers;

  logic        CLK;
  logic        RSTb;
  logic        stall;
  logic [7:0]  regA_sel, regB_sel, regIn_sel, dbg_sel;
  logic [31:0] regIn_data;
  logic        regIn_wr;
  logic [31:0] regA_out, regB_out, dbg_data;

  int n_cmp = 0;
  int n_err = 0;

  slurm32_cpu_registers #(
    .REG_COUNT(32),
    .DATA_BITS(32)
  ) dut (
    .CLK       (CLK),
    .RSTb      (RSTb),
    .stall     (stall),
    .regA_sel  (regA_sel),
    .regB_sel  (regB_sel),
    .regIn_sel (regIn_sel),
    .regIn_data(regIn_data),
    .regIn_wr  (regIn_wr),
    .regA_out  (regA_out),
    .regB_out  (regB_out),
    .dbg_sel   (dbg_sel),
    .dbg_data  (dbg_data)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic write(input logic [7:0] sel, input logic [31:0] data);
    regIn_wr   = 1'b1;
    regIn_sel  = sel;
    regIn_data = data;
    tick();
    regIn_wr   = 1'b0;
  endtask

  task automatic dbg(input string tag, input logic [7:0] sel, input logic [31:0] exp);
    dbg_sel = sel;
    #1;
    check(tag, dbg_data, exp);
  endtask

  initial begin
    RSTb = 1'b0; stall = 1'b0; regIn_wr = 1'b0;
    regA_sel = '0; regB_sel = '0; regIn_sel = '0; regIn_data = '0; dbg_sel = '0;
    tick();
    check("reset_a", regA_out, 32'h0);
    check("reset_b", regB_out, 32'h0);
    dbg("reset_dbg_r4", 8'd4, 32'h0);
    @(negedge CLK);
    RSTb = 1'b1;
    tick();

    // 1: basic write and read
    write(8'd4, 32'h1122_3344);
    write(8'd5, 32'h5566_7788);
    regA_sel = 8'd4; regB_sel = 8'd5;
    tick();
    check("t1_a", regA_out, 32'h1122_3344);
    check("t1_b", regB_out, 32'h5566_7788);
    dbg("t1_dbg_r4", 8'd4, 32'h1122_3344);

    // 2: r0 hardwired, upper select bits honoured
    regA_sel = 8'd0; regB_sel = 8'h21;
    write(8'd0, 32'hDEAD_BEEF);
    check("t2_a_r0", regA_out, 32'h0);
    check("t2_b_oor", regB_out, 32'h0);
    dbg("t2_dbg_r0", 8'd0, 32'h0);
    dbg("t2_dbg_alias_r4", 8'h24, 32'h0);
    write(8'h25, 32'h0000_0BAD);
    dbg("t2_oor_write_dropped", 8'd5, 32'h5566_7788);
    regB_sel = 8'h24;
    tick();
    check("t2_b_alias_r4", regB_out, 32'h0);

    // 3: same-cycle bypass; debug port has no bypass
    regIn_wr = 1'b1; regIn_sel = 8'd7; regIn_data = 32'hCAFE_F00D;
    regA_sel = 8'd7; regB_sel = 8'd4;
    dbg("t3_dbg_no_bypass", 8'd7, 32'h0);
    tick();
    regIn_wr = 1'b0;
    check("t3_a_bypass", regA_out, 32'hCAFE_F00D);
    check("t3_b", regB_out, 32'h1122_3344);
    dbg("t3_dbg_r7", 8'd7, 32'hCAFE_F00D);

    // 4: stall holds outputs, writes land, release re-reads
    regA_sel = 8'd4; regB_sel = 8'd5;
    tick();
    check("t4_pre_a", regA_out, 32'h1122_3344);
    check("t4_pre_b", regB_out, 32'h5566_7788);
    stall = 1'b1;
    regB_sel = 8'd7;
    tick();
    check("t4_hold1_a", regA_out, 32'h1122_3344);
    check("t4_hold1_b", regB_out, 32'h5566_7788);
    write(8'd4, 32'hA5A5_A5A5);
    check("t4_hold2_a", regA_out, 32'h1122_3344);
    check("t4_hold2_b", regB_out, 32'h5566_7788);
    tick();
    check("t4_hold3_a", regA_out, 32'h1122_3344);
    dbg("t4_dbg_r4", 8'd4, 32'hA5A5_A5A5);
    stall = 1'b0;
    tick();
    check("t4_rel_a", regA_out, 32'hA5A5_A5A5);
    check("t4_rel_b", regB_out, 32'hCAFE_F00D);

    // 5: async reset mid-cycle, pending write discarded
    @(posedge CLK);
    #3;
    regIn_wr = 1'b1; regIn_sel = 8'd6; regIn_data = 32'h0000_0066;
    RSTb = 1'b0;
    #1;
    check("t5_a_async", regA_out, 32'h0);
    check("t5_b_async", regB_out, 32'h0);
    dbg("t5_dbg_r4", 8'd4, 32'h0);
    tick();
    check("t5_a_held", regA_out, 32'h0);
    regIn_wr = 1'b0;
    @(negedge CLK);
    RSTb = 1'b1;
    dbg("t5_dbg_r6", 8'd6, 32'h0);

    // 6: shared select, plain and bypassed
    write(8'd3, 32'h0000_0003);
    regA_sel = 8'd3; regB_sel = 8'd3;
    tick();
    check("t6_a", regA_out, 32'h0000_0003);
    check("t6_b", regB_out, 32'h0000_0003);
    regA_sel = 8'd9; regB_sel = 8'd9;
    write(8'd9, 32'h0000_0099);
    check("t6_a_bypass", regA_out, 32'h0000_0099);
    check("t6_b_bypass", regB_out, 32'h0000_0099);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
